// File: rtl/pipe_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_hazard_scoreboard
//
// Interlock controller for the 5-stage pipeline. It sits beside ID and
// decodes the instruction held in IF/ID. It checks that instruction's source
// registers against a shift-register scoreboard of destinations that are
// still in flight. On a read-after-write hazard it holds PC and IF/ID and
// sends a bubble into ID/EX, so programs no longer need dummy OR
// instructions. It also handles the HLT drain and the bookkeeping for a
// branch flush.
//
// Optional feature, selected by the macro HAZ_FORWARD_EN:
//   defined   - EX/MEM->EX forwarding exists, so only a load-use in the
//               youngest slot causes a hazard (one stall cycle).
//   undefined - full interlock. Any valid in-flight destination that
//               matches a source causes a hazard.
//
// Parameters:
//   WB_DIST  cycles after issue before a result is readable in ID (>=1)
//   REG_AW   register address width
//   CNT_W    stall counter width
//
// Ports:
//   clk        pipeline clock, rising edge
//   rst        synchronous active-high reset
//   id_valid   IF/ID holds a valid instruction
//   id_ir      IF/ID instruction: op[31:26] rs[25:21] rt[20:16] rd[15:11]
//   flush      taken branch resolved; kill ID and the youngest issued op
//   stall      hold PC and IF/ID this cycle
//   issue      IF/ID instruction advances into ID/EX this cycle
//   bubble     force a NOP into ID/EX this cycle
//   halted     HLT has issued and the scoreboard is empty
//   stall_cnt  saturating count of stall cycles since reset
// ---------------------------------------------------------------------------
module pipe_hazard_scoreboard #(
  parameter int WB_DIST = 3,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_ir,
  input  logic             flush,
  output logic             stall,
  output logic             issue,
  output logic             bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [5:0]        op;
  logic [REG_AW-1:0] rs, rt, rd;
  logic              rd_rs, rd_rt, writer, wr_load, is_hlt;
  logic [REG_AW-1:0] wr_dest;
  logic              wr_en;
  logic              hazard;
  logic              halt_seen;

  // Scoreboard slots. Slot 0 is the youngest in-flight instruction.
  logic [WB_DIST-1:0] slot_valid;
  logic [WB_DIST-1:0] slot_load;
  logic [REG_AW-1:0]  slot_dest [WB_DIST];

  // The immediate / funct bits never affect interlocking.
  logic unused_ir_bits;
  assign unused_ir_bits = ^id_ir[10:0];

  assign op = id_ir[31:26];
  assign rs = id_ir[21 +: REG_AW];
  assign rt = id_ir[16 +: REG_AW];
  assign rd = id_ir[11 +: REG_AW];

  // Instruction decode. This works out which register fields are read,
  // whether the instruction writes a register, and whether that write comes
  // from a load. Opcodes that are not listed neither read nor write.
  always_comb begin
    rd_rs   = 1'b0;
    rd_rt   = 1'b0;
    writer  = 1'b0;
    wr_load = 1'b0;
    wr_dest = rt;
    is_hlt  = 1'b0;
    if (op <= 6'b000101) begin
      rd_rs   = 1'b1;
      rd_rt   = 1'b1;
      writer  = 1'b1;
      wr_dest = rd;
    end else if (op >= 6'b001010 && op <= 6'b001100) begin
      rd_rs  = 1'b1;
      writer = 1'b1;
    end else begin
      case (op)
        6'b001000: begin
          rd_rs   = 1'b1;
          writer  = 1'b1;
          wr_load = 1'b1;
        end
        6'b001001: begin
          rd_rs = 1'b1;
          rd_rt = 1'b1;
        end
        6'b001101, 6'b001110: rd_rs  = 1'b1;
        6'b111111:            is_hlt = 1'b1;
        default: ;
      endcase
    end
  end

  // R0 is hardwired to zero, so writes to it are never tracked.
  assign wr_en = writer && (wr_dest != '0);

  // Hazard detection. An R0 source can never match, because R0 is never
  // entered into the scoreboard. The explicit check keeps that guarantee
  // local to this block.
`ifdef HAZ_FORWARD_EN
  // With forwarding, only a load in the youngest slot is too late to
  // forward, so that is the only case that stalls.
  always_comb begin
    hazard = 1'b0;
    if (slot_valid[0] && slot_load[0]) begin
      if (rd_rs && rs != '0 && rs == slot_dest[0]) hazard = 1'b1;
      if (rd_rt && rt != '0 && rt == slot_dest[0]) hazard = 1'b1;
    end
  end
`else
  // Without forwarding, a source must wait until its writer has left the
  // scoreboard entirely.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WB_DIST; i++) begin
      if (slot_valid[i]) begin
        if (rd_rs && rs != '0 && rs == slot_dest[i]) hazard = 1'b1;
        if (rd_rt && rt != '0 && rt == slot_dest[i]) hazard = 1'b1;
      end
    end
  end
`endif

  // The pipeline decision is made in the same cycle. A flush or a completed
  // HLT suppresses both issue and stall, so a flush takes priority over a
  // stall.
  assign stall  = id_valid & hazard  & ~flush & ~halt_seen;
  assign issue  = id_valid & ~hazard & ~flush & ~halt_seen;
  assign bubble = ~issue;
  assign halted = halt_seen & ~(|slot_valid);

  // Scoreboard shift register. Every cycle the entries age by one slot and
  // the oldest one retires. On a flush, the instruction that issued last
  // cycle is wrong-path, so it is dropped as it moves from slot 0 to slot 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
      slot_load  <= '0;
      for (int i = 0; i < WB_DIST; i++) slot_dest[i] <= '0;
    end else begin
      slot_valid[0] <= issue & wr_en;
      slot_load[0]  <= issue & wr_en & wr_load;
      slot_dest[0]  <= wr_dest;
      for (int i = 1; i < WB_DIST; i++) begin
        slot_valid[i] <= (i == 1 && flush) ? 1'b0 : slot_valid[i-1];
        slot_load[i]  <= slot_load[i-1];
        slot_dest[i]  <= slot_dest[i-1];
      end
    end
  end

  // Halt tracking and stall statistics. Once HLT issues, nothing else issues
  // until reset. The stall counter stops at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_seen <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (issue && is_hlt) halt_seen <= 1'b1;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_scoreboard
//
// Directed bench for pipe_hazard_scoreboard with WB_DIST=3. The bench plays
// the role of the fetch stage. It keeps an instruction in IF/ID until the
// interlock issues it, and counts the stall and bubble cycles it sees on the
// way. The expected counts are worked out by hand from the pipeline
// timing. When HAZ_FORWARD_EN is defined, the forwarding-mode
// expectations are used instead.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_scoreboard;

`ifdef HAZ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [31:0] ADDI_R1_120 = 32'h28010078;
  localparam logic [31:0] LW_R2_R1    = 32'h20220000;
  localparam logic [31:0] ADDI_R2_45  = 32'h2842002D;
  localparam logic [31:0] ADDI_R2_10  = 32'h2842000A;
  localparam logic [31:0] OR_R3       = 32'h0C631800;
  localparam logic [31:0] SW_R2_R1    = 32'h24220001;
  localparam logic [31:0] HLT         = 32'hFC000000;
  localparam logic [31:0] ADDI_R0_5   = 32'h28000005;
  localparam logic [31:0] ADD_R4_R0   = 32'h00002000;
  localparam logic [31:0] ADDI_R5_1   = 32'h28050001;
  localparam logic [31:0] ADD_R6_R5   = 32'h00A53000;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_ir;
  logic        flush;
  logic        stall, issue, bubble, halted;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  pipe_hazard_scoreboard #(.WB_DIST(3), .REG_AW(5), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_ir     (id_ir),
    .flush     (flush),
    .stall     (stall),
    .issue     (issue),
    .bubble    (bubble),
    .halted    (halted),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Holds reset for two edges with IF/ID empty.
  task automatic doReset();
    rst      = 1'b1;
    id_valid = 1'b0;
    flush    = 1'b0;
    id_ir    = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Places one instruction in IF/ID and keeps it there until it issues.
  // Outputs are sampled on the falling edge. The task returns just after
  // the edge on which the instruction issued, with IF/ID emptied again.
  task automatic applyStimulus(input logic [31:0] ir, input string tag,
                               input int exp_stalls);
    int stalls  = 0;
    int bubbles = 0;
    bit done    = 1'b0;
    id_valid = 1'b1;
    id_ir    = ir;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (issue) done = 1'b1;
      else begin
        if (stall)  stalls++;
        if (bubble) bubbles++;
      end
      @(posedge clk);
      #1;
    end
    id_valid = 1'b0;
    checkOutput({tag, "_issued"},  32'(done),    32'd1);
    checkOutput({tag, "_stalls"},  32'(stalls),  32'(exp_stalls));
    checkOutput({tag, "_bubbles"}, 32'(bubbles), 32'(exp_stalls));
  endtask

  // Advances one clock and lands on the next falling edge.
  task automatic nextSample();
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state, and issue following id_valid when the scoreboard is empty.
    doReset();
    @(negedge clk);
    checkOutput("rst_stall",   32'(stall),     32'd0);
    checkOutput("rst_halted",  32'(halted),    32'd0);
    checkOutput("rst_cnt",     32'(stall_cnt), 32'd0);
    checkOutput("rst_issue0",  32'(issue),     32'd0);
    id_valid = 1'b1;
    id_ir    = ADDI_R1_120;
    #1;
    checkOutput("rst_issue1",  32'(issue),     32'd1);
    checkOutput("rst_bubble",  32'(bubble),    32'd0);
    id_valid = 1'b0;
    @(posedge clk);
    #1;

    // ADDI R1 then LW through R1: three stalls without forwarding.
    doReset();
    applyStimulus(ADDI_R1_120, "addi_r1", 0);
    applyStimulus(LW_R2_R1,    "lw_r1",   FWD ? 0 : 3);
    checkOutput("addi_lw_cnt", 32'(stall_cnt), FWD ? 32'd0 : 32'd3);

    // Load-use: LW R2 then ADDI reading R2.
    doReset();
    applyStimulus(LW_R2_R1,   "lu_lw",   0);
    applyStimulus(ADDI_R2_45, "lu_addi", FWD ? 1 : 3);

    // Independent OR between the load and its use.
    doReset();
    applyStimulus(LW_R2_R1,   "sep_lw",   0);
    applyStimulus(OR_R3,      "sep_or",   0);
    applyStimulus(ADDI_R2_45, "sep_addi", FWD ? 0 : 2);
    checkOutput("sep_cnt", 32'(stall_cnt), FWD ? 32'd0 : 32'd2);

    // Full program without dummy instructions, ending in HLT.
    doReset();
    applyStimulus(ADDI_R1_120, "prog_addi1", 0);
    applyStimulus(LW_R2_R1,    "prog_lw",    FWD ? 0 : 3);
    applyStimulus(ADDI_R2_10,  "prog_addi2", FWD ? 1 : 3);
    applyStimulus(SW_R2_R1,    "prog_sw",    FWD ? 0 : 3);
    applyStimulus(HLT,         "prog_hlt",   0);
    checkOutput("prog_cnt", 32'(stall_cnt), FWD ? 32'd1 : 32'd9);
    id_valid = 1'b1;
    id_ir    = ADDI_R1_120;
    @(negedge clk);
    checkOutput("prog_post_issue", 32'(issue), 32'd0);
    checkOutput("prog_post_stall", 32'(stall), 32'd0);
    nextSample();
    nextSample();
    checkOutput("prog_halted", 32'(halted), 32'd1);
    id_valid = 1'b0;

    // HLT right behind a writer: halted rises exactly three cycles after issue.
    doReset();
    applyStimulus(ADDI_R1_120, "hd_addi", 0);
    applyStimulus(HLT,         "hd_hlt",  0);
    @(negedge clk);
    checkOutput("hd_halted_c1", 32'(halted), 32'd0);
    nextSample();
    checkOutput("hd_halted_c2", 32'(halted), 32'd0);
    nextSample();
    checkOutput("hd_halted_c3", 32'(halted), 32'd1);

    // Writes to R0 are never tracked.
    doReset();
    applyStimulus(ADDI_R0_5, "r0_addi", 0);
    applyStimulus(ADD_R4_R0, "r0_add",  0);

    // A flush kills the writer that issued the cycle before.
    doReset();
    applyStimulus(ADDI_R5_1, "fl_addi", 0);
    id_valid = 1'b1;
    id_ir    = ADD_R6_R5;
    flush    = 1'b1;
    @(negedge clk);
    checkOutput("fl_issue",  32'(issue),  32'd0);
    checkOutput("fl_stall",  32'(stall),  32'd0);
    checkOutput("fl_bubble", 32'(bubble), 32'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    applyStimulus(ADD_R6_R5, "fl_add", 0);

    // Reset asserted during the second stall cycle.
    doReset();
    applyStimulus(ADDI_R1_120, "ms_addi", 0);
    id_valid = 1'b1;
    id_ir    = LW_R2_R1;
    @(negedge clk);
    checkOutput("ms_stall1", 32'(stall), FWD ? 32'd0 : 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("ms_stall", 32'(stall),     32'd0);
    checkOutput("ms_cnt",   32'(stall_cnt), 32'd0);
    checkOutput("ms_halt",  32'(halted),    32'd0);
    checkOutput("ms_issue", 32'(issue),     32'd1);
    id_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
